// File: rtl/pipe_step_pkg.sv
// Shared types for the pipeline run/step/breakpoint controller.
// State encodings match the software-visible state register.
package pipe_step_pkg;

  localparam int DB_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } ctrl_state_e;

  // Freeze the fetch at the breakpoint address in the hit cycle.
  function automatic logic pe_of(
    input ctrl_state_e s,
    input logic        hit
  );
    return (s == ST_STEP) || ((s == ST_RUN) && !hit);
  endfunction

endpackage

// File: rtl/pipe_step_ctrl_btn_debounce.sv
// Step button conditioning: 2-flop sync, stable-count debounce,
// and a one-cycle pulse on each debounced rising edge.
module btn_debounce
  import pipe_step_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic step_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic          db_prev_q, db_prev_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    pulse_d   = db_q & ~db_prev_q;
    db_d      = db_q;
    cnt_d     = '0;
    // Any sample matching the current level restarts the count.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign step_pulse = pulse_q;

endmodule

// File: rtl/pipe_step_ctrl.sv
// Pipeline run/halt/single-step controller with a fetch breakpoint.
// pipe_en gates every pipeline register and the PC.
module pipe_step_ctrl
  import pipe_step_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        brk_en,
  input  logic [31:0] brk_addr,
  input  logic [31:0] pcF,
  output logic        pipe_en,
  output logic [1:0]  state,
  output logic        brk_hit,
  output logic [31:0] cyc_cnt
);

  logic        step_pulse;
  logic        hit;
  ctrl_state_e state_q, state_d;
  logic        brk_hit_q, brk_hit_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn (
    .clk       (clk),
    .rst       (reset),
    .btn_raw   (step_btn),
    .step_pulse(step_pulse)
  );

  assign hit     = brk_en && (pcF == brk_addr);
  assign pipe_en = pe_of(state_q, hit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALT: begin
        // run_sw wins; a coincident pulse is dropped.
        if (run_sw)          state_d = ST_RUN;
        else if (step_pulse) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (!run_sw)  state_d = ST_HALT;
        else if (hit) state_d = ST_BRK;
      end
      ST_STEP: state_d = ST_HALT;
      ST_BRK: begin
        if (!run_sw)         state_d = ST_HALT;
        else if (step_pulse) state_d = ST_STEP;
      end
      default: state_d = ST_HALT;
    endcase
    brk_hit_d = (state_d == ST_BRK);
    cyc_cnt_d = cyc_cnt_q + {31'd0, pipe_en};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HALT;
      brk_hit_q <= 1'b0;
      cyc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      brk_hit_q <= brk_hit_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign state   = state_q;
  assign brk_hit = brk_hit_q;
  assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Self-checking bench for pipe_step_ctrl: directed scenarios then
// random run/button/breakpoint traffic against a behavioural model.
module tb_pipe_step_ctrl;

  localparam int DB   = 16;
  localparam int HALT = 0;
  localparam int RUN  = 1;
  localparam int STEP = 2;
  localparam int BRK  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_sw;
  logic        step_btn;
  logic        brk_en;
  logic [31:0] brk_addr;
  logic [31:0] pcF;
  logic        pipe_en;
  logic [1:0]  state;
  logic        brk_hit;
  logic [31:0] cyc_cnt;

  always #5 clk = ~clk;

  pipe_step_ctrl #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset   (reset),
    .run_sw  (run_sw),
    .step_btn(step_btn),
    .brk_en  (brk_en),
    .brk_addr(brk_addr),
    .pcF     (pcF),
    .pipe_en (pipe_en),
    .state   (state),
    .brk_hit (brk_hit),
    .cyc_cnt (cyc_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model: button history queues, abstract state, counters.
  int          m_st;
  logic [31:0] m_cyc;
  bit          m_pulse;
  bit          m_rose;
  bit          m_db;
  bit          raw_h[$];
  bit          sync_h[$];
  bit          last_pe;
  bit          pc_follow;
  int          pe_count;

  function automatic bit m_hit();
    return brk_en && (pcF == brk_addr);
  endfunction

  function automatic bit m_pe();
    return (m_st == STEP) || (m_st == RUN && !m_hit());
  endfunction

  task automatic m_reset();
    m_st    = HALT;
    m_cyc   = 32'd0;
    m_pulse = 1'b0;
    m_rose  = 1'b0;
    m_db    = 1'b0;
    last_pe = 1'b0;
    raw_h.delete();
    sync_h.delete();
  endtask

  task automatic m_edge();
    bit pe, hit, s, flip;
    int nst;
    if (reset) begin
      m_reset();
      return;
    end
    pe  = m_pe();
    hit = m_hit();
    nst = m_st;
    case (m_st)
      HALT: if (run_sw) nst = RUN; else if (m_pulse) nst = STEP;
      RUN:  if (!run_sw) nst = HALT; else if (hit) nst = BRK;
      STEP: nst = HALT;
      default: if (!run_sw) nst = HALT; else if (m_pulse) nst = STEP;
    endcase
    if (pe) m_cyc = m_cyc + 32'd1;
    last_pe = pe;
    // Synchronized value is the raw level two edges back.
    raw_h.push_back(step_btn);
    s = (raw_h.size() >= 3) ? raw_h[raw_h.size()-3] : 1'b0;
    if (raw_h.size() > 4) void'(raw_h.pop_front());
    sync_h.push_back(s);
    if (sync_h.size() > DB) void'(sync_h.pop_front());
    flip = (sync_h.size() == DB);
    foreach (sync_h[i]) if (sync_h[i] == m_db) flip = 1'b0;
    m_pulse = m_rose;
    m_rose  = 1'b0;
    if (flip) begin
      m_db   = ~m_db;
      m_rose = m_db;
      sync_h.delete();
    end
    m_st = nst;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    if (pc_follow && last_pe) pcF = pcF + 32'd4;
    #1;
    chk("state",   32'(state),   32'(m_st));
    chk("pipe_en", 32'(pipe_en), 32'(m_pe()));
    chk("brk_hit", 32'(brk_hit), 32'(m_st == BRK));
    chk("cyc_cnt", cyc_cnt,      m_cyc);
    if (pipe_en === 1'b1) pe_count++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_reset();
    chk("rst_state",   32'(state),   32'd0);
    chk("rst_pipe_en", 32'(pipe_en), 32'd0);
    chk("rst_brk_hit", 32'(brk_hit), 32'd0);
    chk("rst_cyc_cnt", cyc_cnt,      32'd0);
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int st,
                            input int budget);
    int n = 0;
    while (m_st != st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(state), 32'(st));
  endtask

  initial begin
    int first;
    int n;
    int hold;
    reset     = 1'b1;
    run_sw    = 1'b0;
    step_btn  = 1'b0;
    brk_en    = 1'b0;
    brk_addr  = 32'd0;
    pcF       = 32'd0;
    pc_follow = 1'b0;
    pe_count  = 0;
    do_reset();

    // Clean press held 40 cycles.
    step_btn = 1'b1;
    first    = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (pipe_en === 1'b1 && first < 0) first = i;
    end
    chk("press_latency", 32'(first),    32'd20);
    chk("press_pulses",  32'(pe_count), 32'd1);
    chk("press_cyc",     cyc_cnt,       32'd1);
    chk("press_end",     32'(state),    32'(HALT));
    step_btn = 1'b0;
    ticks(30);

    // Bounce every 5 cycles: must never debounce.
    pe_count = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) step_btn = ~step_btn;
      tick();
    end
    chk("bounce_pe",  32'(pe_count), 32'd0);
    chk("bounce_cyc", cyc_cnt,       32'd1);
    ticks(20);

    // Run into a breakpoint at 0x10.
    do_reset();
    pcF       = 32'd0;
    pc_follow = 1'b1;
    brk_en    = 1'b1;
    brk_addr  = 32'h10;
    run_sw    = 1'b1;
    wait_state("brk_reached", BRK, 20);
    chk("brk_cyc",  cyc_cnt,       32'd4);
    chk("brk_flag", 32'(brk_hit),  32'd1);
    chk("brk_pe",   32'(pipe_en),  32'd0);

    // Step past the breakpoint with run_sw held.
    step_btn = 1'b1;
    wait_state("step_from_brk", STEP, 40);
    chk("step_pe", 32'(pipe_en), 32'd1);
    tick();
    chk("seq_halt", 32'(state), 32'(HALT));
    tick();
    chk("seq_run",    32'(state),   32'(RUN));
    chk("seq_run_pe", 32'(pipe_en), 32'd1);
    step_btn = 1'b0;
    ticks(25);
    chk("no_rehit", 32'(state), 32'(RUN));

    // run_sw rising together with step_pulse in HALT.
    brk_en = 1'b0;
    run_sw = 1'b0;
    ticks(20);
    step_btn = 1'b1;
    n = 0;
    while (!m_pulse && n < 40) begin
      tick();
      n++;
    end
    chk("race_halt", 32'(state), 32'(HALT));
    run_sw = 1'b1;
    tick();
    chk("race_run",    32'(state),   32'(RUN));
    chk("race_run_pe", 32'(pipe_en), 32'd1);
    step_btn = 1'b0;
    ticks(25);

    // Counter wrap.
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt_q;
    m_cyc = 32'hFFFF_FFFF;
    #1;
    chk("wrap_pre", cyc_cnt, 32'hFFFF_FFFF);
    tick();
    chk("wrap", cyc_cnt, 32'd0);

    // Reset mid-debounce aborts the press.
    run_sw = 1'b0;
    tick();
    step_btn = 1'b1;
    ticks(10);
    reset = 1'b1;
    #1;
    m_reset();
    chk("rst_db_state", 32'(state), 32'(HALT));
    step_btn = 1'b0;
    ticks(2);
    reset    = 1'b0;
    pe_count = 0;
    ticks(30);
    chk("abort_db", 32'(pe_count), 32'd0);

    // Reset during STEP.
    step_btn = 1'b1;
    wait_state("reach_step", STEP, 40);
    chk("in_step_pe", 32'(pipe_en), 32'd1);
    reset = 1'b1;
    #1;
    m_reset();
    chk("rst_step_pe",    32'(pipe_en), 32'd0);
    chk("rst_step_state", 32'(state),   32'(HALT));
    step_btn = 1'b0;
    ticks(2);
    reset    = 1'b0;
    pe_count = 0;
    ticks(30);
    chk("abort_step", 32'(pe_count), 32'd0);

    // Random traffic.
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 40 == 0) run_sw = ~run_sw;
      if (hold == 0) begin
        step_btn = 1'($urandom % 2);
        hold     = int'($urandom_range(1, 40));
      end else begin
        hold--;
      end
      if ($urandom % 50 == 0) begin
        brk_en   = 1'($urandom % 2);
        brk_addr = pcF + 32'(4 * $urandom_range(0, 6));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_step_ctrl.md
PIPE_STEP_CTRL -- requirements
Module: pipe_step_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a new button level.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 run_sw  input  1  level switch; 1 requests free-running pipeline.
REQ-005 step_btn  input  1  raw, asynchronous, bouncing single-step button.
REQ-006 brk_en  input  1  breakpoint enable.
REQ-007 brk_addr  input  32  breakpoint fetch address.
REQ-008 pcF  input  32  current fetch-stage PC.
REQ-009 pipe_en  output  1  global enable for every pipeline register and PC; 0 freezes the pipeline.
REQ-010 state  output  2  FSM state: HALT=00, RUN=01, STEP=10, BRK=11.
REQ-011 brk_hit  output  1  high while state is BRK.
REQ-012 cyc_cnt  output  32  count of cycles with pipe_en=1.

Function
REQ-013 step_btn SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Debounced level SHALL change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any return to the old value clears the counter.
REQ-015 A 0->1 change of the debounced level SHALL produce step_pulse, high for exactly one cycle.
REQ-016 hit SHALL be combinational: brk_en=1 and pcF==brk_addr.
REQ-017 pipe_en SHALL be combinational from registered state and hit: 1 in STEP; 1 in RUN when hit=0; 0 otherwise.
REQ-018 HALT: run_sw=1 -> RUN; else step_pulse -> STEP; else stay. When both occur, RUN wins and the step_pulse is discarded.
REQ-019 RUN: run_sw=0 -> HALT; else hit=1 -> BRK. The fetch at brk_addr SHALL NOT advance: pipe_en=0 in the hit cycle.
REQ-020 STEP: lasts exactly one cycle with pipe_en=1, ignores hit, then -> HALT unconditionally.
REQ-021 BRK: run_sw=0 -> HALT; else step_pulse -> STEP, which steps past the breakpoint; else stay.
REQ-022 step_pulse arriving in RUN or STEP SHALL be ignored and not queued.
REQ-023 With run_sw held at 1 after a step from BRK, the FSM goes STEP -> HALT -> RUN. The PC has moved past brk_addr, so execution resumes.
REQ-024 cyc_cnt SHALL increment by 1 in each cycle with pipe_en=1 and wrap from 0xFFFFFFFF to 0.
REQ-025 Total latency from the raw button edge to pipe_en pulse SHALL be 2 (sync) + DB_CYCLES + 1 (pulse) + 1 (state) cycles.

Reset
REQ-026 On reset the block SHALL set:
- state to HALT, so pipe_en=0 and brk_hit=0;
- cyc_cnt to 0;
- synchronizer flops, debounced level and debounce counter to 0.
REQ-027 Reset asserted mid-debounce or mid-STEP SHALL abort the operation with no step_pulse or pipe_en pulse after release.
REQ-028 After reset release the first transition SHALL be evaluated at the first rising clk edge.

Structure
REQ-029 State encodings (HALT/RUN/STEP/BRK) and the DB_CYCLES default SHALL live in the shared package used by the pipeline control logic.
REQ-030 Synchronizer, debouncer and edge detector SHALL be one sub-module, btn_debounce, parameterized by DB_CYCLES, outputting step_pulse.
REQ-031 Debounce counter width SHALL be clog2(DB_CYCLES+1).

Verification
REQ-032 Reset, run_sw=0, step_btn clean press held 40 cycles with DB_CYCLES=16:
- exactly one pipe_en pulse, 20 cycles after press;
- cyc_cnt=1;
- state ends in HALT.
REQ-033 step_btn toggling every 5 cycles for 100 cycles, DB_CYCLES=16: no step_pulse, pipe_en stays 0, cyc_cnt=0.
REQ-034 run_sw=1, brk_en=1, brk_addr=0x0000_0010, pcF counting by 4 from 0:
- pipe_en low in the cycle pcF=0x10;
- state=BRK, brk_hit=1;
- cyc_cnt=4.
REQ-035 From BRK, one debounced press with run_sw=1:
- sequence STEP, HALT, RUN;
- pipe_en high in the STEP cycle and from RUN onward;
- no re-hit while pcF=0x14.
REQ-036 In HALT, run_sw rising in the same cycle as step_pulse: next state RUN, no STEP visit.
REQ-037 cyc_cnt forced near wrap (0xFFFFFFFF) in RUN: reads 0 after one enabled cycle. Reset asserted during STEP: pipe_en=0 immediately, state=HALT.
